// File: rtl/matrix_skewer_if.sv
// matrix_skewer_if: capture/stream bus between matrix storage and the skewer.
// Master drives start plus the 4x4 matrix; the skewer slave returns the skewed lanes.
interface matrix_skewer_if #(parameter int WIDTH = 32);
   logic             start;
   logic [WIDTH-1:0] m11, m12, m13, m14;
   logic [WIDTH-1:0] m21, m22, m23, m24;
   logic [WIDTH-1:0] m31, m32, m33, m34;
   logic [WIDTH-1:0] m41, m42, m43, m44;
   logic [WIDTH-1:0] d1, d2, d3, d4;
   logic             v1, v2, v3, v4;
   logic [2:0]       step;
   logic             busy, done;
   modport master (
      output start, m11, m12, m13, m14, m21, m22, m23, m24,
             m31, m32, m33, m34, m41, m42, m43, m44,
      input  d1, d2, d3, d4, v1, v2, v3, v4, step, busy, done
   );
   modport slave (
      input  start, m11, m12, m13, m14, m21, m22, m23, m24,
             m31, m32, m33, m34, m41, m42, m43, m44,
      output d1, d2, d3, d4, v1, v2, v3, v4, step, busy, done
   );
endinterface

// File: rtl/matrix_skewer.sv
// matrix_skewer: captures a 4x4 matrix and replays it as a 7-step diagonal skew on 4 lanes.
// Lane k at step t carries m[k+max(0,t-3)][t-row] while k < min(t+1, 7-t).
module matrix_skewer #(parameter int WIDTH = 32) (
   input  logic           clk,
   input  logic           rst_n,
   matrix_skewer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_m [16];
   logic [WIDTH-1:0] w_in [16];
   logic [WIDTH-1:0] r_d [4];
   logic [WIDTH-1:0] w_d [4];
   logic [3:0]       r_v, w_v;
   logic [2:0]       r_step, w_t, w_n;
   logic [1:0]       w_off;
   logic [1:0]       w_row [4];
   logic [1:0]       w_col [4];
   logic             r_busy, r_done;
   assign w_in = '{bus.m11, bus.m12, bus.m13, bus.m14, bus.m21, bus.m22, bus.m23, bus.m24,
                   bus.m31, bus.m32, bus.m33, bus.m34, bus.m41, bus.m42, bus.m43, bus.m44};
   // w_t is the step about to be displayed after the coming edge
   assign w_t   = (r_state == LOAD) ? 3'd0 : r_step + 3'd1;
   assign w_n   = (w_t < 3'd4) ? w_t + 3'd1 : 3'd7 - w_t;
   assign w_off = (w_t > 3'd3) ? 2'(w_t - 3'd3) : 2'd0;
   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign w_row[k] = 2'(k) + w_off;
      assign w_col[k] = 2'(w_t - {1'b0, w_row[k]});
      assign w_v[k]   = 3'(k) < w_n;
      assign w_d[k]   = w_v[k] ? r_m[{w_row[k], w_col[k]}] : '0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_step  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_v     <= '0;
         r_d     <= '{default: '0};
         r_m     <= '{default: '0};
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               r_m     <= w_in;
               r_busy  <= 1'b1;
               r_state <= LOAD;
            end
            LOAD: begin
               r_step  <= w_t;
               r_d     <= w_d;
               r_v     <= w_v;
               r_done  <= 1'b0;
               r_state <= STREAM;
            end
            STREAM: if (r_step == 3'd6) begin
               r_step <= '0;
               r_d    <= '{default: '0};
               r_v    <= '0;
               r_done <= 1'b0;
               // the edge that ends a stream can already accept the next one
               if (bus.start) begin
                  r_m     <= w_in;
                  r_state <= LOAD;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end else begin
               r_step <= w_t;
               r_d    <= w_d;
               r_v    <= w_v;
               r_done <= (w_t == 3'd6);
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign {bus.d4, bus.d3, bus.d2, bus.d1} = {r_d[3], r_d[2], r_d[1], r_d[0]};
   assign {bus.v4, bus.v3, bus.v2, bus.v1} = r_v;
   assign bus.step = r_step;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
endmodule

// File: tb/tb_matrix_skewer.sv
// tb_matrix_skewer: directed scenarios for the matrix skewer with hand-derived expected lanes.
// Outputs are sampled 1 time unit after each rising edge.
module tb_matrix_skewer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   matrix_skewer_if #(.WIDTH(32)) bus();
   matrix_skewer #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   int checks = 0;
   int errors = 0;
   logic [31:0] mat [16];
   logic [31:0] matb [16];
   logic [31:0] cap [16];
   // element index (4*(i-1)+(j-1)) carried by each lane at each step
   int idx_t [7][4] = '{'{0,0,0,0}, '{1,4,0,0}, '{2,5,8,0}, '{3,6,9,12},
                        '{7,10,13,0}, '{11,14,0,0}, '{15,0,0,0}};
   logic [3:0] vmask [7] = '{4'h1, 4'h3, 4'h7, 4'hf, 4'h7, 4'h3, 4'h1};
   logic [127:0] dv;
   logic [3:0]   vv;
   assign dv = {bus.d4, bus.d3, bus.d2, bus.d1};
   assign vv = {bus.v4, bus.v3, bus.v2, bus.v1};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [31:0] base, input logic [31:0] stride);
      for (int i = 0; i < 16; i++) mat[i] = base + stride * 32'(i);
   endtask

   task automatic put();
      bus.m11 = mat[0];  bus.m12 = mat[1];  bus.m13 = mat[2];  bus.m14 = mat[3];
      bus.m21 = mat[4];  bus.m22 = mat[5];  bus.m23 = mat[6];  bus.m24 = mat[7];
      bus.m31 = mat[8];  bus.m32 = mat[9];  bus.m33 = mat[10]; bus.m34 = mat[11];
      bus.m41 = mat[12]; bus.m42 = mat[13]; bus.m43 = mat[14]; bus.m44 = mat[15];
   endtask

   function automatic logic [127:0] expd(input int t);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 4; k++) if (vmask[t][k]) r[k*32 +: 32] = cap[idx_t[t][k]];
      return r;
   endfunction

   task automatic test_reset();
      fill(32'h55, 1); put();
      rst_n = 1'b0; bus.start = 1'b1;
      tick();
      checks++;
      if ({vv, bus.step, bus.busy, bus.done, dv} !== '0) begin
         errors++;
         $display("FAIL reset: got v=%b step=%0d busy=%b done=%b d=%h, expected all zero", vv, bus.step, bus.busy, bus.done, dv);
      end
      rst_n = 1'b1; bus.start = 1'b0;
      tick();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_start: busy=%b expected 0", bus.busy);
      end
   endtask

   task automatic test_stream();
      logic [136:0] o, e;
      fill(32'h0, 32'h1); put(); cap = mat;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || vv !== 4'h0) begin
         errors++;
         $display("FAIL stream_load: busy=%b v=%b expected busy=1 v=0", bus.busy, vv);
      end
      for (int t = 0; t < 7; t++) begin
         tick();
         o = {bus.step, vv, bus.done, bus.busy, dv};
         e = {3'(t), vmask[t], t == 6, 1'b1, expd(t)};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL stream_step%0d: got %h expected %h", t, o, e);
         end
      end
      tick();
      checks++;
      if ({vv, bus.busy, bus.step, bus.done, dv} !== '0) begin
         errors++;
         $display("FAIL stream_end: got v=%b busy=%b step=%0d done=%b, expected all zero", vv, bus.busy, bus.step, bus.done);
      end
   endtask

   task automatic test_loopback();
      logic [31:0] agg [4][4];
      int t, row;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) agg[r][c] = 32'hx;
      fill(32'h0, 32'h1); put(); cap = mat;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (8) begin
         tick();
         if (bus.busy === 1'b1) begin
            t = int'(bus.step);
            for (int k = 0; k < 4; k++) if (vv[k] === 1'b1) begin
               row = k + ((t > 3) ? t - 3 : 0);
               if (row < 4 && t - row >= 0 && t - row < 4) agg[row][t - row] = dv[k*32 +: 32];
            end
         end
      end
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
         checks++;
         if (agg[r][c] !== 32'(4 * r + c)) begin
            errors++;
            $display("FAIL loopback_r%0d%0d: got %h expected %h", r + 1, c + 1, agg[r][c], 32'(4 * r + c));
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [136:0] o, e;
      int nb;
      fill(32'h0a000000, 32'h01010101); put(); cap = mat;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      nb = (bus.busy === 1'b1) ? 1 : 0;
      for (int t = 0; t < 7; t++) begin
         tick();
         if (bus.busy === 1'b1) nb++;
         o = {bus.step, vv, bus.done, bus.busy, dv};
         e = {3'(t), vmask[t], t == 6, 1'b1, expd(t)};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL ignore_step%0d: got %h expected %h", t, o, e);
         end
         if (t == 2) begin
            bus.start = 1'b1; fill(32'hdeadbeef, 32'h0); put();
         end else bus.start = 1'b0;
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0 || nb != 8 || vv !== 4'h0) begin
         errors++;
         $display("FAIL ignore_busy: busy=%b busy_cycles=%0d v=%b expected busy=0 busy_cycles=8 v=0", bus.busy, nb, vv);
      end
      tick();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_no_queue: busy=%b expected 0", bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [136:0] o, e;
      fill(32'h2000, 32'h7); matb = mat;
      fill(32'h1000, 32'h11); put(); cap = mat;
      bus.start = 1'b1;
      tick();
      mat = matb; put();
      for (int t = 0; t < 7; t++) begin
         tick();
         o = {bus.step, vv, bus.done, bus.busy, dv};
         e = {3'(t), vmask[t], t == 6, 1'b1, expd(t)};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b_a_step%0d: got %h expected %h", t, o, e);
         end
      end
      tick();
      checks++;
      if (vv !== 4'h0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap: v=%b busy=%b expected v=0 busy=1", vv, bus.busy);
      end
      cap = matb;
      fill(32'h1000, 32'h11); put();
      for (int t = 0; t < 7; t++) begin
         tick();
         bus.start = 1'b0;
         o = {bus.step, vv, bus.done, bus.busy, dv};
         e = {3'(t), vmask[t], t == 6, 1'b1, expd(t)};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b_b_step%0d: got %h expected %h", t, o, e);
         end
      end
      tick();
      checks++;
      if (vv !== 4'h0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: v=%b busy=%b expected v=0 busy=0", vv, bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      fill(32'h0, 32'h1); put(); cap = mat;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      checks++;
      if (bus.step !== 3'd3 || vv !== 4'hf) begin
         errors++;
         $display("FAIL rstmid_pre: step=%0d v=%b expected step=3 v=1111", bus.step, vv);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if ({vv, bus.step, bus.busy, bus.done, dv} !== '0) begin
         errors++;
         $display("FAIL rstmid: got v=%b step=%0d busy=%b done=%b d=%h, expected all zero", vv, bus.step, bus.busy, bus.done, dv);
      end
      bad = 0;
      repeat (12) begin
         tick();
         if (vv !== 4'h0 || bus.busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rstmid_quiet: %0d active cycles, expected 0", bad);
      end
   endtask

   task automatic test_inactive();
      fill(32'hffffffff, 32'h0); put(); cap = mat;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      checks++;
      if ({vv, dv} !== {4'b0001, 96'h0, 32'hffffffff}) begin
         errors++;
         $display("FAIL inactive_step0: v=%b d=%h expected v=0001 d=%h", vv, dv, {96'h0, 32'hffffffff});
      end
      repeat (5) tick();
      checks++;
      if ({bus.step, vv, dv} !== {3'd5, 4'b0011, 64'h0, 64'hffffffffffffffff}) begin
         errors++;
         $display("FAIL inactive_step5: step=%0d v=%b d=%h expected step=5 v=0011 d=%h", bus.step, vv, dv, {64'h0, 64'hffffffffffffffff});
      end
      repeat (2) tick();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL inactive_end: busy=%b expected 0", bus.busy);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      fill(32'h0, 32'h0); put();
      test_reset();
      test_stream();
      test_loopback();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_inactive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
